// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types and constants for the PLL reset sequencer.
package pll_seq_pkg;

    localparam int RETRY_W = 8;

    typedef enum logic [2:0] {
        RESET,
        WAIT_LOCK,
        STABLE,
        RELEASE,
        RUN,
        FAULT
    } pll_seq_state_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// PLL-side and domain-side signals of the reset sequencer.
// master: the sequencer itself; slave: the PLL / system around it.
interface pll_reset_sequencer_if #(
    parameter int N_DOM = 3
);
    import pll_seq_pkg::*;

    logic               restart;
    logic               pll_locked;
    logic               pll_rst;
    logic [N_DOM-1:0]   dom_rst;
    logic               ready;
    logic [RETRY_W-1:0] retry_cnt;

    modport master (
        input  restart, pll_locked,
        output pll_rst, dom_rst, ready, retry_cnt
    );

    modport slave (
        output restart, pll_locked,
        input  pll_rst, dom_rst, ready, retry_cnt
    );

endinterface

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level (PLL lock).
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the raw level through two flops; cleared on reset so lock is
    // never assumed until it has been seen after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset / start-up sequencer.
// Holds the PLL in reset, waits for a debounced lock (with timeout and
// retry), releases domain resets one at a time, then watches for lock loss.
// Optional macro PLL_SEQ_AUTO_RELOCK_EN: lock loss re-runs the sequence
// instead of parking in a sticky FAULT state.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_HOLD_CYCLES     = 16,
    parameter int LOCK_STABLE_CYCLES  = 64,
    parameter int LOCK_TIMEOUT_CYCLES = 4096,
    parameter int N_DOM               = 3,
    parameter int STAGGER_CYCLES      = 4
) (
    input  logic                  clk,
    input  logic                  cpu_reset,
    pll_reset_sequencer_if.master bus
);

    localparam int MAX_P = max2(max2(RST_HOLD_CYCLES, LOCK_STABLE_CYCLES),
                                max2(LOCK_TIMEOUT_CYCLES, N_DOM * STAGGER_CYCLES));
    localparam int CNT_W = $clog2(MAX_P) + 1;
    // Last RELEASE count before the final domain comes out of reset.
    localparam int REL_LAST = (N_DOM > 1) ? (N_DOM - 1) * STAGGER_CYCLES - 1 : 0;

`ifdef PLL_SEQ_AUTO_RELOCK_EN
    localparam pll_seq_state_e LOSS_STATE = RESET;
`else
    localparam pll_seq_state_e LOSS_STATE = FAULT;
`endif

    pll_seq_state_e     state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [N_DOM-1:0]   dom_rst_q, dom_rst_d;
    logic               pll_rst_q, ready_q;
    logic               lock_s;

    sync_2ff u_lock_sync (
        .clk (clk),
        .rst (cpu_reset),
        .d   (bus.pll_locked),
        .q   (lock_s)
    );

    // Next state, shared counter, retry count and next registered outputs.
    // The counter clears on every state change and only advances while the
    // state is held, so it can never wrap.
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        retry_d   = retry_q;
        dom_rst_d = '1;

        case (state_q)
            RESET: begin
                if (cnt_q == CNT_W'(RST_HOLD_CYCLES - 1)) state_d = WAIT_LOCK;
                else                                      cnt_d   = cnt_q + 1'b1;
            end
            WAIT_LOCK: begin
                // Lock takes priority over a coincident timeout.
                if (lock_s) begin
                    state_d = STABLE;
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
                    state_d = RESET;
                    if (retry_q != '1) retry_d = retry_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STABLE: begin
                if (!lock_s)                                     state_d = WAIT_LOCK;
                else if (cnt_q == CNT_W'(LOCK_STABLE_CYCLES - 1)) state_d = (N_DOM == 1) ? RUN : RELEASE;
                else                                             cnt_d   = cnt_q + 1'b1;
            end
            RELEASE: begin
                if (!lock_s)                        state_d = LOSS_STATE;
                else if (cnt_q == CNT_W'(REL_LAST)) state_d = RUN;
                else                                cnt_d   = cnt_q + 1'b1;
            end
            RUN: begin
                if (!lock_s) state_d = LOSS_STATE;
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: state_d = RESET;
        endcase

        // Soft restart overrides everything except an ongoing reset hold.
        if (bus.restart && state_q != RESET) begin
            state_d = RESET;
            cnt_d   = '0;
            retry_d = retry_q;
        end

        // Domain i leaves reset once the RELEASE count reaches i*STAGGER.
        if (state_d == RELEASE) begin
            for (int i = 0; i < N_DOM; i++)
                dom_rst_d[i] = (cnt_d < CNT_W'(i * STAGGER_CYCLES));
        end else if (state_d == RUN) begin
            dom_rst_d = '0;
        end
    end

    // State, counter and registered outputs; reset forces the safe state at once.
    always_ff @(posedge clk or posedge cpu_reset) begin
        if (cpu_reset) begin
            state_q   <= RESET;
            cnt_q     <= '0;
            retry_q   <= '0;
            pll_rst_q <= 1'b1;
            dom_rst_q <= '1;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            pll_rst_q <= (state_d == RESET) || (state_d == FAULT);
            dom_rst_q <= dom_rst_d;
            ready_q   <= (state_d == RUN);
        end
    end

    assign bus.pll_rst   = pll_rst_q;
    assign bus.dom_rst   = dom_rst_q;
    assign bus.ready     = ready_q;
    assign bus.retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: expected output-change events (cycle offset
// plus output values) are queued with the stimulus and matched in order
// against the changes seen on the DUT outputs.
module tb_pll_reset_sequencer;

    logic clk = 1'b0;
    logic cpu_reset;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    pll_reset_sequencer_if #(.N_DOM(3)) bus ();

    pll_reset_sequencer #(
        .RST_HOLD_CYCLES     (4),
        .LOCK_STABLE_CYCLES  (8),
        .LOCK_TIMEOUT_CYCLES (32),
        .N_DOM               (3),
        .STAGGER_CYCLES      (2)
    ) dut (
        .clk       (clk),
        .cpu_reset (cpu_reset),
        .bus       (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [15:0] d;
        logic        pll_rst;
        logic [2:0]  dom;
        logic        ready;
        logic [7:0]  retry;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];

    task automatic push(input int d, input logic p, input logic [2:0] dom,
                        input logic r, input logic [7:0] rt);
        ev_t ev;
        ev = {16'(d), p, dom, r, rt};
        exp_q.push_back(ev);
    endtask

    // Record every change of the output tuple for n cycles, stamped relative to base.
    task automatic collect(input int base, input int n);
        logic [12:0] prev_o, cur_o;
        ev_t ev;
        prev_o = {bus.pll_rst, bus.dom_rst, bus.ready, bus.retry_cnt};
        repeat (n) begin
            @(negedge clk);
            cur_o = {bus.pll_rst, bus.dom_rst, bus.ready, bus.retry_cnt};
            if (cur_o !== prev_o) begin
                ev = {16'(cyc - base), cur_o};
                obs_q.push_back(ev);
                prev_o = cur_o;
            end
        end
    endtask

    task automatic start_seq(input logic lock, output int base);
        cpu_reset = 1'b1;
        bus.pll_locked = lock;
        repeat (3) @(negedge clk);
        cpu_reset = 1'b0;
        base = cyc;
    endtask

    task automatic test_reset;
        cpu_reset = 1'b1;
        bus.restart = 1'b0;
        bus.pll_locked = 1'b1;
        @(negedge clk);
        checks++; if (bus.pll_rst !== 1'b1)    begin failures++; $display("FAIL reset_pll_rst got=%b exp=1", bus.pll_rst); end
        checks++; if (bus.dom_rst !== 3'b111)  begin failures++; $display("FAIL reset_dom_rst got=%b exp=111", bus.dom_rst); end
        checks++; if (bus.ready !== 1'b0)      begin failures++; $display("FAIL reset_ready got=%b exp=0", bus.ready); end
        checks++; if (bus.retry_cnt !== 8'd0)  begin failures++; $display("FAIL reset_retry got=%0d exp=0", bus.retry_cnt); end
    endtask

    task automatic test_nominal;
        int base;
        ev_t e, o;
        start_seq(1'b1, base);
        push(4,  1'b0, 3'b111, 1'b0, 8'd0);
        push(13, 1'b0, 3'b110, 1'b0, 8'd0);
        push(15, 1'b0, 3'b100, 1'b0, 8'd0);
        push(17, 1'b0, 3'b000, 1'b1, 8'd0);
        collect(base, 20);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin failures++; $display("FAIL nominal missing got=none exp=%h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin failures++; $display("FAIL nominal got=%h exp=%h", o, e); end end
        end
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL nominal_extra got=%0d exp=0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_glitch;
        int base;
        ev_t e, o;
        start_seq(1'b1, base);
        push(4,  1'b0, 3'b111, 1'b0, 8'd0);
        push(22, 1'b0, 3'b110, 1'b0, 8'd0);
        push(24, 1'b0, 3'b100, 1'b0, 8'd0);
        push(26, 1'b0, 3'b000, 1'b1, 8'd0);
        fork
            begin
                repeat (8) @(negedge clk);
                bus.pll_locked = 1'b0;
                repeat (3) @(negedge clk);
                bus.pll_locked = 1'b1;
            end
            collect(base, 30);
        join
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin failures++; $display("FAIL glitch missing got=none exp=%h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin failures++; $display("FAIL glitch got=%h exp=%h", o, e); end end
        end
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL glitch_extra got=%0d exp=0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_lock_loss_run;
        int base;
        ev_t e, o;
        base = cyc;
        push(3,  1'b1, 3'b111, 1'b0, 8'd0);
`ifdef PLL_SEQ_AUTO_RELOCK_EN
        push(7,  1'b0, 3'b111, 1'b0, 8'd0);
        push(16, 1'b0, 3'b110, 1'b0, 8'd0);
        push(18, 1'b0, 3'b100, 1'b0, 8'd0);
        push(20, 1'b0, 3'b000, 1'b1, 8'd0);
        push(41, 1'b1, 3'b111, 1'b0, 8'd0);
`endif
        push(45, 1'b0, 3'b111, 1'b0, 8'd0);
        push(54, 1'b0, 3'b110, 1'b0, 8'd0);
        push(56, 1'b0, 3'b100, 1'b0, 8'd0);
        push(58, 1'b0, 3'b000, 1'b1, 8'd0);
        fork
            begin
                bus.pll_locked = 1'b0;
                repeat (5) @(negedge clk);
                bus.pll_locked = 1'b1;
                repeat (35) @(negedge clk);
                bus.restart = 1'b1;
                @(negedge clk);
                bus.restart = 1'b0;
            end
            collect(base, 70);
        join
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin failures++; $display("FAIL lock_loss missing got=none exp=%h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin failures++; $display("FAIL lock_loss got=%h exp=%h", o, e); end end
        end
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL lock_loss_extra got=%0d exp=0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_restart_with_loss;
        int base;
        ev_t e, o;
        base = cyc;
        push(3,  1'b1, 3'b111, 1'b0, 8'd0);
        push(7,  1'b0, 3'b111, 1'b0, 8'd0);
        push(16, 1'b0, 3'b110, 1'b0, 8'd0);
        push(18, 1'b0, 3'b100, 1'b0, 8'd0);
        push(20, 1'b0, 3'b000, 1'b1, 8'd0);
        fork
            begin
                bus.pll_locked = 1'b0;
                repeat (2) @(negedge clk);
                bus.restart = 1'b1;
                @(negedge clk);
                bus.restart = 1'b0;
                bus.pll_locked = 1'b1;
            end
            collect(base, 25);
        join
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin failures++; $display("FAIL restart_loss missing got=none exp=%h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin failures++; $display("FAIL restart_loss got=%h exp=%h", o, e); end end
        end
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL restart_loss_extra got=%0d exp=0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_timeout;
        int base;
        ev_t e, o;
        start_seq(1'b0, base);
        push(4,  1'b0, 3'b111, 1'b0, 8'd0);
        push(36, 1'b1, 3'b111, 1'b0, 8'd1);
        push(40, 1'b0, 3'b111, 1'b0, 8'd1);
        push(72, 1'b1, 3'b111, 1'b0, 8'd2);
        push(76, 1'b0, 3'b111, 1'b0, 8'd2);
        push(91, 1'b0, 3'b110, 1'b0, 8'd2);
        push(93, 1'b0, 3'b100, 1'b0, 8'd2);
        push(95, 1'b0, 3'b000, 1'b1, 8'd2);
        fork
            begin
                repeat (80) @(negedge clk);
                bus.pll_locked = 1'b1;
            end
            collect(base, 100);
        join
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin failures++; $display("FAIL timeout missing got=none exp=%h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin failures++; $display("FAIL timeout got=%h exp=%h", o, e); end end
        end
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL timeout_extra got=%0d exp=0", obs_q.size()); obs_q.delete(); end
    endtask

    // Restart from RUN (retry count must survive), then hit cpu_reset while dom_rst=100.
    task automatic test_async_reset;
        int base;
        ev_t e, o;
        base = cyc;
        push(1,  1'b1, 3'b111, 1'b0, 8'd2);
        push(5,  1'b0, 3'b111, 1'b0, 8'd2);
        push(14, 1'b0, 3'b110, 1'b0, 8'd2);
        push(16, 1'b0, 3'b100, 1'b0, 8'd2);
        fork
            begin
                bus.restart = 1'b1;
                @(negedge clk);
                bus.restart = 1'b0;
            end
            collect(base, 16);
        join
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin failures++; $display("FAIL async_pre missing got=none exp=%h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin failures++; $display("FAIL async_pre got=%h exp=%h", o, e); end end
        end
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL async_pre_extra got=%0d exp=0", obs_q.size()); obs_q.delete(); end
        #2 cpu_reset = 1'b1;
        #1;
        checks++; if (bus.dom_rst !== 3'b111)  begin failures++; $display("FAIL async_dom_rst got=%b exp=111", bus.dom_rst); end
        checks++; if (bus.pll_rst !== 1'b1)    begin failures++; $display("FAIL async_pll_rst got=%b exp=1", bus.pll_rst); end
        checks++; if (bus.ready !== 1'b0)      begin failures++; $display("FAIL async_ready got=%b exp=0", bus.ready); end
        checks++; if (bus.retry_cnt !== 8'd0)  begin failures++; $display("FAIL async_retry got=%0d exp=0", bus.retry_cnt); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_glitch();
        test_lock_loss_run();
        test_restart_with_loss();
        test_timeout();
        test_async_reset();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
